// File: rtl/burst_addr_gen.sv
// Serial burst address generator: shifts in a start address and a burst
// length, then emits one serial address per beat (FIXED / INCR / WRAP),
// waiting for a downstream acknowledge between beats.
module burst_addr_gen #(
    parameter int ADDR_WIDTH = 20,
    parameter int LEN_WIDTH  = 4,
    parameter int STRIDE     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode_sel,
    input  logic [1:0] burst_type,
    input  logic       abort,
    input  logic       addr_in,
    input  logic       burst_len_in,
    input  logic       beat_ack,
    output logic       addr_ser_out,
    output logic       addr_ser_valid,
    output logic       addr_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_W     = $clog2(ADDR_WIDTH + 1);
    localparam int STRIDE_SH = $clog2(STRIDE);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] LEN_CNT  = CNT_W'(LEN_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_SHIFT,
        S_WAIT_ACK
    } state_t;

    typedef enum logic [1:0] {
        BT_FIXED = 2'b00,
        BT_INCR  = 2'b01,
        BT_WRAP  = 2'b10,
        BT_RSVD  = 2'b11
    } burst_t;

    state_t                r_state;
    burst_t                r_type;
    logic                  r_mode;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beat;
    logic [ADDR_WIDTH-1:0] r_shift;
    logic                  r_valid;
    logic                  r_sel;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    // Next values of the serial load registers (new bit enters at the LSB).
    logic [ADDR_WIDTH-1:0] w_base_next;
    logic [LEN_WIDTH-1:0]  w_len_next;
    logic [LEN_WIDTH-1:0]  w_last_next;
    logic                  w_wrap_bad_next;

    assign w_base_next = ADDR_WIDTH'({r_base, addr_in});
    assign w_len_next  = (r_bit_cnt < LEN_CNT) ? LEN_WIDTH'({r_len, burst_len_in}) : r_len;
    assign w_last_next = r_mode ? w_len_next : '0;

    // Beats = last+1 is a power of two exactly when last & (last+1) == 0;
    // the all-ones case wraps to zero, which is the 2^LEN_WIDTH case.
    assign w_wrap_bad_next = (r_type == BT_WRAP) &&
                             ((w_last_next & (w_last_next + LEN_WIDTH'(1))) != '0);

    // Beat address arithmetic, all modulo 2^ADDR_WIDTH.
    logic [LEN_WIDTH-1:0]  w_last_beat;
    logic [ADDR_WIDTH-1:0] w_beats;
    logic [ADDR_WIDTH-1:0] w_mask;
    logic [ADDR_WIDTH-1:0] w_sum;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_last_beat = r_mode ? r_len : '0;
    assign w_beats     = ADDR_WIDTH'(w_last_beat) + ADDR_WIDTH'(1);
    assign w_mask      = (w_beats << STRIDE_SH) - ADDR_WIDTH'(1);
    assign w_sum       = r_base + (ADDR_WIDTH'(r_beat) << STRIDE_SH);

    // Select the beat address by burst type; reserved type behaves as INCR.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves w_addr unassigned (avoids a latch).
        w_addr = w_sum;
        case (r_type)
            BT_FIXED: w_addr = r_base;
            BT_WRAP:  w_addr = (r_base & ~w_mask) | (w_sum & w_mask);
            default:  w_addr = w_sum;
        endcase
    end

    // Transaction sequencer: load, per-beat address calc, serial shift, ack wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_type    <= BT_FIXED;
            r_mode    <= 1'b0;
            r_bit_cnt <= '0;
            r_base    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_sel     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if ((r_state != S_IDLE) && abort) begin
                r_state   <= S_IDLE;
                r_valid   <= 1'b0;
                r_sel     <= 1'b0;
                r_busy    <= 1'b0;
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state   <= S_LOAD;
                            r_type    <= burst_t'(burst_type);
                            r_mode    <= mode_sel;
                            r_bit_cnt <= '0;
                            r_len     <= '0;
                            r_beat    <= '0;
                            r_sel     <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        r_base <= w_base_next;
                        r_len  <= w_len_next;
                        r_beat <= '0;
                        if (r_bit_cnt == CNT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_CALC;
                            // Raised here so the pulse lands in the CALC cycle itself.
                            r_err     <= w_wrap_bad_next;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                    S_CALC: begin
                        if (r_err) begin
                            r_state <= S_IDLE;
                            r_sel   <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_shift   <= w_addr;
                            r_valid   <= 1'b1;
                            r_bit_cnt <= '0;
                            r_state   <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        r_shift <= r_shift << 1;
                        if (r_bit_cnt == CNT_LAST) begin
                            r_bit_cnt <= '0;
                            r_valid   <= 1'b0;
                            r_state   <= S_WAIT_ACK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                    S_WAIT_ACK: begin
                        if (beat_ack) begin
                            if (r_beat == w_last_beat) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                                r_sel   <= 1'b0;
                                r_busy  <= 1'b0;
                            end else begin
                                r_beat  <= r_beat + LEN_WIDTH'(1);
                                r_state <= S_CALC;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_sel   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The shift register drains to zero, so the serial line idles low.
    assign addr_ser_out   = r_shift[ADDR_WIDTH-1];
    assign addr_ser_valid = r_valid;
    assign addr_sel       = r_sel;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;

endmodule

// File: tb/tb_burst_addr_gen.sv
// Self-checking bench for burst_addr_gen: an arithmetic address model feeds an
// expected-word queue that a serial monitor compares against every beat.
module tb_burst_addr_gen;

    localparam int AW     = 20;
    localparam int LW     = 4;
    localparam int STRIDE = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       mode_sel = 1'b0;
    logic [1:0] burst_type = 2'b00;
    logic       abort = 1'b0;
    logic       addr_in = 1'b0;
    logic       burst_len_in = 1'b0;
    logic       beat_ack = 1'b0;
    logic       addr_ser_out;
    logic       addr_ser_valid;
    logic       addr_sel;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    burst_addr_gen #(
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .STRIDE    (STRIDE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode_sel      (mode_sel),
        .burst_type    (burst_type),
        .abort         (abort),
        .addr_in       (addr_in),
        .burst_len_in  (burst_len_in),
        .beat_ack      (beat_ack),
        .addr_ser_out  (addr_ser_out),
        .addr_ser_valid(addr_ser_valid),
        .addr_sel      (addr_sel),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          words_seen = 0;
    int          bit_cnt = 0;
    int          partial_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          valid_cnt = 0;
    int          first_valid_cyc = -1;
    int          start_cyc = 0;
    int          exp_done = 0;
    logic [AW-1:0] cur_word = '0;
    int unsigned exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Address of beat i straight from the burst rules, using plain integer arithmetic.
    function automatic int unsigned model_addr(input int unsigned base, input int unsigned i,
                                               input logic [1:0] bt, input int unsigned beats);
        int unsigned space;
        int unsigned blk;
        space = 32'd1 << AW;
        case (bt)
            2'b00: return base;
            2'b10: begin
                blk = beats * STRIDE;
                return (base / blk) * blk + ((base + i * STRIDE) % blk);
            end
            default: return (base + i * STRIDE) % space;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Serial monitor: reassembles words MSB first and compares each to the model queue.
    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (!rst) bit_cnt = 0;
        if (addr_ser_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            check("valid_implies_busy", {31'd0, busy}, 32'd1);
            cur_word = {cur_word[AW-2:0], addr_ser_out};
            bit_cnt++;
            if (bit_cnt == AW) begin
                bit_cnt = 0;
                words_seen++;
                if (exp_q.size() == 0) check("unexpected_word", {12'd0, cur_word}, 32'hFFFF_FFFF);
                else check("beat_addr", {12'd0, cur_word}, exp_q.pop_front());
            end
        end else if (bit_cnt != 0) begin
            partial_cnt++;
            bit_cnt = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_words(input int target);
        for (int k = 0; k < 200 && words_seen < target; k++) tick();
        check("word_arrived", words_seen, target);
    endtask

    // Issue start, then shift in address (MSB first) and length (first LW cycles).
    // Mode and type are flipped after the start edge to show they were captured.
    task automatic load_cmd(input logic [AW-1:0] base, input logic [LW-1:0] len,
                            input logic [1:0] bt, input logic md);
        tick();
        start = 1'b1;
        burst_type = bt;
        mode_sel = md;
        tick();
        start_cyc = cyc;
        first_valid_cyc = -1;
        start = 1'b0;
        burst_type = ~bt;
        mode_sel = ~md;
        for (int k = 0; k < AW; k++) begin
            addr_in = base[AW-1-k];
            burst_len_in = (k < LW) ? len[LW-1-k] : 1'b1;
            tick();
        end
        addr_in = 1'b0;
        burst_len_in = 1'b0;
    endtask

    task automatic run_burst(input logic [AW-1:0] base, input logic [LW-1:0] len,
                             input logic [1:0] bt, input logic md,
                             input int ack_wait, input logic poke_start);
        int beats;
        int w0;
        int d0;
        beats = md ? int'(len) + 1 : 1;
        w0 = words_seen;
        d0 = done_cnt;
        for (int i = 0; i < beats; i++) exp_q.push_back(model_addr(base, i, bt, beats));
        load_cmd(base, len, bt, md);
        check("calc_err_low", {31'd0, err}, 32'd0);
        check("calc_sel_high", {31'd0, addr_sel}, 32'd1);
        for (int b = 1; b <= beats; b++) begin
            wait_words(w0 + b);
            if (b == 1) check("first_bit_latency", first_valid_cyc - start_cyc, AW + 1);
            tick();
            check("wait_valid_low", {31'd0, addr_ser_valid}, 32'd0);
            for (int k = 0; k < ack_wait; k++) begin
                if (poke_start) start = 1'b1;
                tick();
                start = 1'b0;
            end
            beat_ack = 1'b1;
            tick();
            beat_ack = 1'b0;
        end
        exp_done++;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy_low", {31'd0, busy}, 32'd0);
        check("done_sel_low", {31'd0, addr_sel}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        int w0;
        int d0;
        int v0;
        int e0;
        int p0;

        // Reset state
        repeat (3) tick();
        check("rst_ser_out", {31'd0, addr_ser_out}, 32'd0);
        check("rst_valid", {31'd0, addr_ser_valid}, 32'd0);
        check("rst_sel", {31'd0, addr_sel}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b1;
        tick();

        // Hand-computed pins of the model
        check("model_incr", model_addr(32'h000F0, 3, 2'b01, 4), 32'h000F3);
        check("model_wrap", model_addr(32'h0000E, 2, 2'b10, 4), 32'h0000C);
        check("model_wrap3", model_addr(32'h0000E, 3, 2'b10, 4), 32'h0000D);
        check("model_roll", model_addr(32'hFFFFE, 2, 2'b01, 4), 32'h00000);
        check("model_fixed", model_addr(32'h12345, 2, 2'b00, 3), 32'h12345);

        // INCR, WRAP (with ack delay and a start poke while busy), FIXED, single, rollover, type 11
        run_burst(20'h000F0, 4'd3, 2'b01, 1'b1, 0, 1'b0);
        run_burst(20'h0000E, 4'd3, 2'b10, 1'b1, 3, 1'b1);
        run_burst(20'h12345, 4'd2, 2'b00, 1'b1, 0, 1'b0);
        run_burst(20'h12345, 4'd7, 2'b01, 1'b0, 1, 1'b0);
        run_burst(20'hFFFFE, 4'd3, 2'b01, 1'b1, 0, 1'b0);
        run_burst(20'h000F0, 4'd1, 2'b11, 1'b1, 0, 1'b0);

        // Illegal WRAP length: err in CALC, nothing emitted
        v0 = valid_cnt; d0 = done_cnt; e0 = err_cnt;
        load_cmd(20'h0000E, 4'd2, 2'b10, 1'b1);
        check("wrap_err_pulse", {31'd0, err}, 32'd1);
        check("wrap_err_busy", {31'd0, busy}, 32'd1);
        tick();
        check("wrap_err_cleared", {31'd0, err}, 32'd0);
        check("wrap_err_idle", {31'd0, busy}, 32'd0);
        check("wrap_err_sel", {31'd0, addr_sel}, 32'd0);
        repeat (25) tick();
        check("wrap_err_no_valid", valid_cnt - v0, 0);
        check("wrap_err_no_done", done_cnt - d0, 0);
        check("wrap_err_once", err_cnt - e0, 1);

        // Abort during the second beat's shift
        w0 = words_seen; d0 = done_cnt; p0 = partial_cnt;
        exp_q.push_back(model_addr(32'h00100, 0, 2'b01, 4));
        load_cmd(20'h00100, 4'd3, 2'b01, 1'b1);
        wait_words(w0 + 1);
        tick();
        beat_ack = 1'b1;
        tick();
        beat_ack = 1'b0;
        for (int k = 0; k < 50 && bit_cnt < 5; k++) tick();
        check("abort_in_shift", {31'd0, addr_ser_valid}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", {31'd0, addr_ser_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sel", {31'd0, addr_sel}, 32'd0);
        check("abort_ser_out", {31'd0, addr_ser_out}, 32'd0);
        repeat (30) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_more_words", words_seen - w0, 1);
        check("abort_partial", partial_cnt - p0, 1);

        // beat_ack held high throughout: acks outside WAIT_ACK are ignored
        w0 = words_seen; d0 = done_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(model_addr(32'h000F0, i, 2'b01, 4));
        beat_ack = 1'b1;
        load_cmd(20'h000F0, 4'd3, 2'b01, 1'b1);
        for (int b = 1; b <= 4; b++) wait_words(w0 + b);
        for (int k = 0; k < 20 && !done; k++) tick();
        check("stray_done", {31'd0, done}, 32'd1);
        beat_ack = 1'b0;
        exp_done++;
        tick();
        check("stray_done_count", done_cnt - d0, 1);
        check("stray_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-shift, then a normal burst
        w0 = words_seen;
        load_cmd(20'hFFFFF, 4'd1, 2'b01, 1'b1);
        for (int k = 0; k < 50 && bit_cnt < 3; k++) tick();
        check("pre_rst_ser_out", {31'd0, addr_ser_out}, 32'd1);
        rst = 1'b0;
        #1;
        check("arst_valid", {31'd0, addr_ser_valid}, 32'd0);
        check("arst_ser_out", {31'd0, addr_ser_out}, 32'd0);
        check("arst_sel", {31'd0, addr_sel}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b1;
        repeat (25) tick();
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        check("post_rst_no_words", words_seen - w0, 0);
        run_burst(20'h000F0, 4'd3, 2'b01, 1'b1, 0, 1'b0);

        repeat (5) tick();
        check("exp_queue_drained", exp_q.size(), 0);
        check("total_done", done_cnt, exp_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_addr_gen.md
Name: burst_addr_gen

Overview:
- Parametrised serial burst address generator. Loads a start address and a burst length serially, then emits one address per beat, serially, on the shared address line.
- Supports FIXED, INCR and WRAP burst types and a configurable address stride.
- Each beat is gated by a completion acknowledge from downstream.
- Sits between the serial command front-end and the STP/PTS address mux; drives that mux's select.

Parameters:
- ADDR_WIDTH, 20, address width in bits; must be >= LEN_WIDTH.
- LEN_WIDTH, 4, burst length field width; beats = field+1 (1..2^LEN_WIDTH).
- STRIDE, 1, address increment per beat; must be a power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begins a transaction; honoured only in IDLE.
- mode_sel  in  1  0 = single transfer (one beat, length field ignored), 1 = burst.
- burst_type  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR; sampled with start.
- abort  in  1  synchronous cancel of the current transaction.
- addr_in  in  1  serial start address, MSB first.
- burst_len_in  in  1  serial length field, MSB first.
- beat_ack  in  1  downstream finished the current beat.
- addr_ser_out  out  1  serial beat address, MSB first.
- addr_ser_valid  out  1  high on every cycle addr_ser_out carries a bit.
- addr_sel  out  1  mux select; high from LOAD until the transaction ends.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final beat is acknowledged.
- err  out  1  one-cycle pulse on an illegal WRAP length.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; all internal registers 0.
- States: IDLE, LOAD, CALC, SHIFT, WAIT_ACK.
- IDLE -> LOAD: start=1 at edge t. burst_type and mode_sel are captured at that edge.
- LOAD: cycles t+1 .. t+ADDR_WIDTH.
  - addr_in is sampled every cycle (ADDR_WIDTH bits).
  - burst_len_in is sampled only in the first LEN_WIDTH cycles of LOAD.
  - beat counter is cleared.
- CALC: one cycle.
  - If WRAP and beats is not a power of two: err pulses in this cycle, then -> IDLE. No address is emitted and done does not pulse.
  - Otherwise: compute the beat address into the shift register, then -> SHIFT.
- SHIFT: ADDR_WIDTH cycles; addr_ser_valid=1, MSB first. The first bit appears at cycle t+ADDR_WIDTH+2. Then -> WAIT_ACK.
- WAIT_ACK: addr_ser_valid=0; wait for beat_ack.
  - beat_ack on the last beat: done pulses next cycle together with the transition to IDLE.
  - beat_ack on any other beat: beat counter increments, then -> CALC.
  - beat_ack asserted in any state other than WAIT_ACK is ignored.
- Address arithmetic, for beat i (0-based), all modulo 2^ADDR_WIDTH:
  - FIXED: base.
  - INCR: base + i*STRIDE, wrapping through zero.
  - WRAP: mask = beats*STRIDE-1; addr = (base & ~mask) | ((base + i*STRIDE) & mask).
- Single mode: beats = 1 regardless of burst_len_in.
- abort=1 in any non-IDLE state: -> IDLE next edge. addr_ser_valid, addr_sel and busy drop that edge; no done, no err. abort has priority over beat_ack.
- start while busy: ignored.
- Reset mid-operation: outputs clear immediately (asynchronous). The next transaction needs a fresh start.
- addr_sel is low in IDLE, including the cycle in which done pulses.
- Pipelining: no overlap between beats; the next CALC starts only after beat_ack.

Test Plan (ADDR_WIDTH=20, LEN_WIDTH=4, STRIDE=1):
- INCR burst: base 0x000F0, length field 3, ack each beat -> serial words 0x000F0, 0x000F1, 0x000F2, 0x000F3; done one cycle after the 4th ack; first bit 22 cycles after start.
- WRAP burst: base 0x0000E, length field 3 -> 0x0000E, 0x0000F, 0x0000C, 0x0000D, then done. Same with length field 2 -> err pulse in CALC, addr_ser_valid never asserted, back to IDLE.
- FIXED and single mode:
  - FIXED, base 0x12345, length field 2 -> 0x12345 three times.
  - mode_sel=0, length field 7 -> exactly one word 0x12345, then done.
- Address rollover: INCR, base 0xFFFFE, length field 3 -> 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Abort and stray ack: abort during the 2nd beat's SHIFT -> IDLE next cycle, no done. beat_ack held high during SHIFT -> no premature beat advance.
- Reset: rst low mid-SHIFT -> addr_ser_out, addr_ser_valid, addr_sel and busy go 0 without a clock edge. A new start after release runs a normal INCR burst.
